// File: rtl/alu_iter_pkg.sv
// ALU control codes and single-cycle operation helpers shared by the iterative ALU.
`default_nettype none

package alu_iter_pkg;

  localparam logic [3:0] ALU_ADD          = 4'b0000;
  localparam logic [3:0] ALU_SUB          = 4'b0001;
  localparam logic [3:0] ALU_AND          = 4'b0010;
  localparam logic [3:0] ALU_OR           = 4'b0011;
  localparam logic [3:0] ALU_XOR          = 4'b0100;
  localparam logic [3:0] ALU_LSHIFT_LEFT  = 4'b0101;
  localparam logic [3:0] ALU_LSHIFT_RIGHT = 4'b0110;
  localparam logic [3:0] ALU_ASHIFT_RIGHT = 4'b0111;

  // Unknown (X/Z) codes fall through to the default arm and read as illegal.
  function automatic logic is_legal(input logic [3:0] ctrl);
    case (ctrl)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_LSHIFT_LEFT, ALU_LSHIFT_RIGHT, ALU_ASHIFT_RIGHT: is_legal = 1'b1;
      default:                                             is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_shift(input logic [3:0] ctrl);
    case (ctrl)
      ALU_LSHIFT_LEFT, ALU_LSHIFT_RIGHT, ALU_ASHIFT_RIGHT: is_shift = 1'b1;
      default:                                             is_shift = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] alu_basic(input logic [3:0] ctrl,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    case (ctrl)
      ALU_ADD: alu_basic = a + b;
      ALU_SUB: alu_basic = a - b;
      ALU_AND: alu_basic = a & b;
      ALU_OR:  alu_basic = a | b;
      ALU_XOR: alu_basic = a ^ b;
      default: alu_basic = 32'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_shift_step.sv
// One-bit shift: left when direction=0, right when direction=1 (sign fill if arith).
`default_nettype none

module alu_shift_step (
  input  logic [31:0] value,
  input  logic        direction,
  input  logic        arith,
  output logic [31:0] shifted
);

  always_comb begin
    shifted = {value[30:0], 1'b0};
    if (direction) begin
      shifted = {arith & value[31], value[31:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_iter.sv
// Iterative 32-bit ALU: logic/arith ops in one cycle, shifts one bit per cycle.
`default_nettype none

module alu_iter
  import alu_iter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_ctrl,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        lt,
  output logic        ltu,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  ctrl_q;
  logic [31:0] acc;
  logic [4:0]  cnt;
  logic [31:0] shifted;
  logic        accept;
  logic        req_shift;
  logic [31:0] basic_res;

  assign accept    = in_valid && in_ready;
  assign req_shift = is_shift(alu_ctrl);
  assign basic_res = alu_basic(alu_ctrl, op_a, op_b);
  assign result    = acc;

  alu_shift_step u_shift_step (
    .value     (acc),
    .direction (ctrl_q != ALU_LSHIFT_LEFT),
    .arith     (ctrl_q == ALU_ASHIFT_RIGHT),
    .shifted   (shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) begin
          state_nx = (req_shift && (op_b[4:0] != 5'd0)) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (cnt == 5'd1) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // acc doubles as the shift working register and the presented result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= 4'd0;
      acc    <= 32'd0;
      cnt    <= 5'd0;
      zero   <= 1'b0;
      lt     <= 1'b0;
      ltu    <= 1'b0;
      err    <= 1'b0;
    end else if (accept) begin
      ctrl_q <= alu_ctrl;
      lt     <= $signed(op_a) < $signed(op_b);
      ltu    <= op_a < op_b;
      err    <= !is_legal(alu_ctrl);
      if (req_shift) begin
        acc  <= op_a;
        cnt  <= op_b[4:0];
        zero <= (op_a == 32'd0);
      end else begin
        acc  <= basic_res;
        cnt  <= 5'd0;
        zero <= (basic_res == 32'd0);
      end
    end else if (state == SHIFT) begin
      acc  <= shifted;
      cnt  <= cnt - 5'd1;
      zero <= (shifted == 32'd0);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: directed corner cases plus randomized ops vs a reference model.
`default_nettype none

module tb_alu_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        lt;
  logic        ltu;
  logic        err;

  int passed = 0;
  int total  = 0;

  alu_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .lt        (lt),
    .ltu       (ltu),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_res(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (c)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[4:0];
      4'd6: r = a >> b[4:0];
      4'd7: r = $signed(a) >>> b[4:0];
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [3:0] c, input logic [31:0] b);
    if (c >= 4'd5 && c <= 4'd7) return 1 + int'(b[4:0]);
    return 1;
  endfunction

  // Issue one request, scramble inputs after accept, return cycles until out_valid (64 = timeout).
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; alu_ctrl = 4'($urandom); op_a = $urandom; op_b = $urandom;
    lat = 0;
    while (lat < 64) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_ctrl = 4'd0; op_a = 32'd0; op_b = 32'd0;
    #17;
    total++;
    if ({out_valid, result, zero, lt, ltu, err} !== 37'd0) begin
      $display("FAIL reset_outputs: got ov=%b res=%h z=%b lt=%b ltu=%b err=%b, want all 0",
               out_valid, result, zero, lt, ltu, err);
    end else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else passed++;
  endtask

  task automatic test_add_sub;
    int lat;
    run_op(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, lat);
    total++;
    if (result !== 32'h8000_0000 || zero !== 1'b0 || lat != 1)
      $display("FAIL add_wrap: got res=%h z=%b lat=%0d want 80000000 0 1", result, zero, lat);
    else passed++;
    consume();
    run_op(4'd1, 32'd5, 32'd5, lat);
    total++;
    if (result !== 32'd0 || zero !== 1'b1 || lt !== 1'b0 || ltu !== 1'b0)
      $display("FAIL sub_equal: got res=%h z=%b lt=%b ltu=%b want 0 1 0 0", result, zero, lt, ltu);
    else passed++;
    consume();
    run_op(4'd1, 32'hFFFF_FFFF, 32'd1, lat);
    total++;
    if (lt !== 1'b1 || ltu !== 1'b0 || result !== 32'hFFFF_FFFE)
      $display("FAIL sub_signs: got lt=%b ltu=%b res=%h want 1 0 fffffffe", lt, ltu, result);
    else passed++;
    consume();
  endtask

  task automatic test_shifts;
    int lat;
    run_op(4'd7, 32'h8000_0000, 32'd4, lat);
    total++;
    if (result !== 32'hF800_0000 || lat != 5)
      $display("FAIL sra_4: got res=%h lat=%0d want f8000000 5", result, lat);
    else passed++;
    consume();
    run_op(4'd5, 32'h1, 32'd31, lat);
    total++;
    if (result !== 32'h8000_0000 || lat != 32)
      $display("FAIL sll_31: got res=%h lat=%0d want 80000000 32", result, lat);
    else passed++;
    consume();
    run_op(4'd5, 32'hDEAD_BEEF, 32'hFFFF_FFE0, lat);
    total++;
    if (result !== 32'hDEAD_BEEF || lat != 1)
      $display("FAIL sll_0: got res=%h lat=%0d want deadbeef 1", result, lat);
    else passed++;
    consume();
  endtask

  task automatic test_illegal;
    int lat;
    run_op(4'b1111, 32'h1234_5678, 32'h9, lat);
    total++;
    if (err !== 1'b1 || result !== 32'd0 || zero !== 1'b1 || lat != 1)
      $display("FAIL illegal: got err=%b res=%h z=%b lat=%0d want 1 0 1 1", err, result, zero, lat);
    else passed++;
    consume();
  endtask

  task automatic test_backpressure;
    int lat;
    run_op(4'd4, 32'hA5A5_0F0F, 32'h0F0F_FFFF, lat);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (result !== 32'hAAAA_F0F0 || out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL hold_done: cycle %0d got res=%h ov=%b ir=%b want aaaaf0f0 1 0",
                 i, result, out_valid, in_ready);
      else passed++;
    end
    @(negedge clk);
    out_ready = 1'b1;
    total++;
    if (in_ready !== 1'b0) $display("FAIL handshake_cycle_ready: got %b want 0", in_ready);
    else passed++;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL after_handshake: got ir=%b ov=%b want 1 0", in_ready, out_valid);
    else passed++;
  endtask

  task automatic test_reset_mid_shift;
    bit seen = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = 4'd6; op_a = 32'hFFFF_0000; op_b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || result !== 32'd0)
      $display("FAIL reset_mid_shift: got ov=%b res=%h want 0 0", out_valid, result);
    else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready);
    else passed++;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total++;
    if (seen) $display("FAIL dropped_op: got out_valid=1 after reset want 0");
    else passed++;
  endtask

  task automatic test_random;
    int lat;
    logic [3:0]  c;
    logic [31:0] a, b;
    for (int n = 0; n < 40; n++) begin
      c = (n % 5 == 4) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      if (n % 7 == 0) b = a;
      run_op(c, a, b, lat);
      total++;
      if (result !== model_res(c, a, b) || lat != model_lat(c, b) ||
          zero !== (model_res(c, a, b) == 32'd0) || err !== (c > 4'd7) ||
          lt !== ($signed(a) < $signed(b)) || ltu !== (a < b))
        $display("FAIL random[%0d]: c=%h a=%h b=%h got res=%h lat=%0d z=%b lt=%b ltu=%b err=%b want res=%h lat=%0d",
                 n, c, a, b, result, lat, zero, lt, ltu, err, model_res(c, a, b), model_lat(c, b));
      else passed++;
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_shifts();
    test_illegal();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
